// File: rtl/seq_controller.sv
// seq_controller: multi-cycle operand-fetch/execute sequencer for the 8-bit datapath.
// Define SEQ_CONTROLLER_EXT_OPS_EN to add the xor, xor_a and shl opcodes.
module seq_controller #(
  parameter int unsigned       ADDR_W     = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op,
  input  logic [3:0]        opcode,
  input  logic              stall,
  output logic [ADDR_W-1:0] address,
  output logic [2:0]        alu_signals,
  output logic              acc_load,
  output logic              acc_mux,
  output logic              a_load,
  output logic              b_load,
  output logic              busy,
  output logic              done,
  output logic              illegal
);

  typedef enum logic [1:0] {StIdle, StLoadA, StLoadB, StExec} state_e;
  typedef enum logic [1:0] {GrpIllegal, GrpTwo, GrpAcc, GrpAccOnly} grp_e;

  function automatic grp_e op_group(input logic [3:0] code);
    grp_e g;
    case (code)
      4'b0000, 4'b0010, 4'b0100, 4'b0110: g = GrpTwo;
      4'b0001, 4'b0011, 4'b0101, 4'b0111: g = GrpAcc;
      4'b1000:                            g = GrpAccOnly;
`ifdef SEQ_CONTROLLER_EXT_OPS_EN
      4'b1001:                            g = GrpTwo;
      4'b1010:                            g = GrpAcc;
      4'b1011:                            g = GrpAccOnly;
`endif
      default:                            g = GrpIllegal;
    endcase
    return g;
  endfunction

  function automatic logic [2:0] op_alu(input logic [3:0] code);
    logic [2:0] a;
    case (code)
      4'b0000, 4'b0001: a = 3'b000;
      4'b0010, 4'b0011: a = 3'b001;
      4'b0100, 4'b0101: a = 3'b010;
      4'b0110, 4'b0111: a = 3'b011;
      4'b1000:          a = 3'b100;
`ifdef SEQ_CONTROLLER_EXT_OPS_EN
      4'b1001, 4'b1010: a = 3'b101;
      4'b1011:          a = 3'b110;
`endif
      default:          a = 3'b000;
    endcase
    return a;
  endfunction

  state_e            state_q, state_d;
  logic [3:0]        opc_q, opc_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [2:0]        alu_q, alu_d;
  logic              acc_mux_q, acc_mux_d;
  logic              a_load_q, b_load_q, exec_q;
  logic              illegal_q, illegal_d;
  logic              accept;
  grp_e              new_grp;

  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    illegal_d = 1'b0;
    address_d = address_q;
    new_grp   = op_group(opcode);
    accept    = op && !stall && (state_q == StIdle || state_q == StExec);

    if (!stall) begin
      unique case (state_q)
        StIdle:  state_d = StIdle;
        StLoadA: state_d = StLoadB;
        StLoadB: state_d = StExec;
        StExec:  state_d = StIdle;
      endcase
      if (state_q == StLoadA || state_q == StLoadB) begin
        address_d = address_q + ADDR_W'(1);
      end
    end

    // An illegal op only pulses the flag; the in-flight EXEC (if any) still completes.
    if (accept) begin
      if (new_grp == GrpIllegal) begin
        illegal_d = 1'b1;
        state_d   = StIdle;
      end else begin
        opc_d = opcode;
        unique case (new_grp)
          GrpTwo:     state_d = StLoadA;
          GrpAcc:     state_d = StLoadB;
          GrpAccOnly: state_d = StExec;
          GrpIllegal: state_d = StIdle;
        endcase
      end
    end

    alu_d     = (state_d == StExec) ? op_alu(opc_d) : 3'b000;
    acc_mux_d = (state_d == StExec) && (op_group(opc_d) != GrpTwo);
  end

  // Moore outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      opc_q     <= 4'b0000;
      address_q <= RESET_ADDR;
      alu_q     <= 3'b000;
      acc_mux_q <= 1'b0;
      a_load_q  <= 1'b0;
      b_load_q  <= 1'b0;
      exec_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      address_q <= address_d;
      alu_q     <= alu_d;
      acc_mux_q <= acc_mux_d;
      a_load_q  <= (state_d == StLoadA);
      b_load_q  <= (state_d == StLoadB);
      exec_q    <= (state_d == StExec);
      illegal_q <= illegal_d;
    end
  end

  // Stall masks the write enables of the held cycle; it replays once stall drops.
  assign a_load      = a_load_q & ~stall;
  assign b_load      = b_load_q & ~stall;
  assign acc_load    = exec_q & ~stall;
  assign done        = exec_q & ~stall;
  assign acc_mux     = acc_mux_q;
  assign alu_signals = alu_q;
  assign address     = address_q;
  assign busy        = (state_q != StIdle);
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_seq_controller.sv
// Directed bench for seq_controller: a default instance (ADDR_W=4) and a 2-bit wrap instance.
// Row format: {reset, op, opcode, stall, expected outputs, expected address}.
module tb_seq_controller;

  logic       clk;
  logic       reset, op, stall;
  logic [3:0] opcode;
  logic [3:0] address;
  logic [2:0] alu_signals;
  logic       acc_load, acc_mux, a_load, b_load, busy, done, illegal;

  logic       w_reset, w_op, w_stall;
  logic [3:0] w_opcode;
  logic [1:0] w_address;
  logic [2:0] w_alu_signals;
  logic       w_acc_load, w_acc_mux, w_a_load, w_b_load, w_busy, w_done, w_illegal;

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] obs, w_obs;
  assign obs   = {busy, a_load, b_load, acc_load, done, acc_mux, illegal, alu_signals};
  assign w_obs = {w_busy, w_a_load, w_b_load, w_acc_load, w_done, w_acc_mux, w_illegal,
                  w_alu_signals};

  localparam logic [9:0] IDL = 10'b0000000000;
  localparam logic [9:0] LA  = 10'b1100000000;
  localparam logic [9:0] LB  = 10'b1010000000;
  localparam logic [9:0] ILL = 10'b0000001000;
  localparam logic [9:0] SLB = 10'b1000000000;  // LOAD_B while stalled
  localparam logic [9:0] SEX = 10'b1000000001;  // EXEC of sub while stalled

  seq_controller dut (
    .clk(clk), .reset(reset), .op(op), .opcode(opcode), .stall(stall),
    .address(address), .alu_signals(alu_signals), .acc_load(acc_load), .acc_mux(acc_mux),
    .a_load(a_load), .b_load(b_load), .busy(busy), .done(done), .illegal(illegal)
  );

  seq_controller #(.ADDR_W(2), .RESET_ADDR(2'd3)) dut_w (
    .clk(clk), .reset(w_reset), .op(w_op), .opcode(w_opcode), .stall(w_stall),
    .address(w_address), .alu_signals(w_alu_signals), .acc_load(w_acc_load),
    .acc_mux(w_acc_mux), .a_load(w_a_load), .b_load(w_b_load), .busy(w_busy),
    .done(w_done), .illegal(w_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] ex(input logic m, input logic [2:0] a);
    return {5'b10011, m, 1'b0, a};
  endfunction

  function automatic logic [20:0] row(input logic r, input logic o, input logic [3:0] c,
                                      input logic s, input logic [9:0] e, input logic [3:0] a);
    return {r, o, c, s, e, a};
  endfunction

  function automatic logic [20:0] iss(input logic [3:0] c, input logic [9:0] e,
                                      input logic [3:0] a);
    return row(1'b1, 1'b1, c, 1'b0, e, a);
  endfunction

  // Non-issuing cycle; opcode deliberately left at a non-zero code to show it is ignored.
  function automatic logic [20:0] nx(input logic [9:0] e, input logic [3:0] a);
    return row(1'b1, 1'b0, 4'hB, 1'b0, e, a);
  endfunction

  task automatic pulse_reset();
    reset = 1'b0; op = 1'b0; stall = 1'b0; opcode = 4'h0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [20:0] q[$];
    reset = 1'b0; op = 1'b1; opcode = 4'h0; stall = 1'b0;
    @(posedge clk); #1;
    q.push_back(row(1'b0, 1'b1, 4'h0, 1'b0, IDL, 4'd0));
    q.push_back(row(1'b0, 1'b1, 4'h0, 1'b0, IDL, 4'd0));
    q.push_back(iss(4'b0000, IDL, 4'd0));
    q.push_back(nx(LA, 4'd0));
    q.push_back(nx(LB, 4'd1));
    q.push_back(nx(ex(1'b0, 3'b000), 4'd2));
    q.push_back(nx(IDL, 4'd2));
    foreach (q[i]) begin
      {reset, op, opcode, stall} = q[i][20:14];
      #1;
      n_cmp++;
      if (obs !== q[i][13:4] || address !== q[i][3:0]) begin
        n_err++;
        $display("FAIL reset[%0d]: obs=%b addr=%0d, expected obs=%b addr=%0d",
                 i, obs, address, q[i][13:4], q[i][3:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sweep();
    logic [20:0] q[$];
    q = '{iss(4'b0000, IDL, 4'd2),  nx(LA, 4'd2),  nx(LB, 4'd3),  nx(ex(1'b0, 3'b000), 4'd4),
          iss(4'b0001, IDL, 4'd4),  nx(LB, 4'd4),  nx(ex(1'b1, 3'b000), 4'd5),  nx(IDL, 4'd5),
          iss(4'b0010, IDL, 4'd5),  nx(LA, 4'd5),  nx(LB, 4'd6),  nx(ex(1'b0, 3'b001), 4'd7),
          iss(4'b0011, IDL, 4'd7),  nx(LB, 4'd7),  nx(ex(1'b1, 3'b001), 4'd8),  nx(IDL, 4'd8),
          iss(4'b0100, IDL, 4'd8),  nx(LA, 4'd8),  nx(LB, 4'd9),  nx(ex(1'b0, 3'b010), 4'd10),
          iss(4'b0101, IDL, 4'd10), nx(LB, 4'd10), nx(ex(1'b1, 3'b010), 4'd11), nx(IDL, 4'd11),
          iss(4'b0110, IDL, 4'd11), nx(LA, 4'd11), nx(LB, 4'd12), nx(ex(1'b0, 3'b011), 4'd13),
          iss(4'b0111, IDL, 4'd13), nx(LB, 4'd13), nx(ex(1'b1, 3'b011), 4'd14), nx(IDL, 4'd14),
          iss(4'b1000, IDL, 4'd14), nx(ex(1'b1, 3'b100), 4'd14), nx(IDL, 4'd14), nx(IDL, 4'd14)};
`ifdef SEQ_CONTROLLER_EXT_OPS_EN
    q.push_back(iss(4'b1001, IDL, 4'd14)); q.push_back(nx(LA, 4'd14));
    q.push_back(nx(LB, 4'd15));            q.push_back(nx(ex(1'b0, 3'b101), 4'd0));
    q.push_back(iss(4'b1010, IDL, 4'd0));  q.push_back(nx(LB, 4'd0));
    q.push_back(nx(ex(1'b1, 3'b101), 4'd1)); q.push_back(nx(IDL, 4'd1));
    q.push_back(iss(4'b1011, IDL, 4'd1));  q.push_back(nx(ex(1'b1, 3'b110), 4'd1));
    q.push_back(nx(IDL, 4'd1));
    q.push_back(iss(4'b1100, IDL, 4'd1));  q.push_back(nx(ILL, 4'd1));
    q.push_back(iss(4'b1111, IDL, 4'd1));  q.push_back(nx(ILL, 4'd1));
    q.push_back(nx(IDL, 4'd1));
`else
    q.push_back(iss(4'b1001, IDL, 4'd14)); q.push_back(nx(ILL, 4'd14));
    q.push_back(nx(IDL, 4'd14));
    q.push_back(iss(4'b1011, IDL, 4'd14)); q.push_back(nx(ILL, 4'd14));
    q.push_back(iss(4'b1111, IDL, 4'd14)); q.push_back(nx(ILL, 4'd14));
    q.push_back(nx(IDL, 4'd14));
`endif
    foreach (q[i]) begin
      {reset, op, opcode, stall} = q[i][20:14];
      #1;
      n_cmp++;
      if (obs !== q[i][13:4] || address !== q[i][3:0]) begin
        n_err++;
        $display("FAIL sweep[%0d]: obs=%b addr=%0d, expected obs=%b addr=%0d",
                 i, obs, address, q[i][13:4], q[i][3:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] q[$];
    pulse_reset();
    q = '{iss(4'b0011, IDL, 4'd0),
          row(1'b1, 1'b1, 4'b0111, 1'b0, LB, 4'd0),                 // ignored in LOAD_B
          row(1'b1, 1'b1, 4'b0001, 1'b0, ex(1'b1, 3'b001), 4'd1),   // accepted in EXEC
          nx(LB, 4'd1), nx(ex(1'b1, 3'b000), 4'd2), iss(4'b0000, IDL, 4'd2),
          nx(LA, 4'd2), nx(LB, 4'd3),
          row(1'b1, 1'b1, 4'b1111, 1'b0, ex(1'b0, 3'b000), 4'd4),   // illegal during EXEC
          nx(ILL, 4'd4), iss(4'b1000, IDL, 4'd4),
          row(1'b1, 1'b1, 4'b1000, 1'b0, ex(1'b1, 3'b100), 4'd4),
          nx(ex(1'b1, 3'b100), 4'd4), nx(IDL, 4'd4)};
    foreach (q[i]) begin
      {reset, op, opcode, stall} = q[i][20:14];
      #1;
      n_cmp++;
      if (obs !== q[i][13:4] || address !== q[i][3:0]) begin
        n_err++;
        $display("FAIL b2b[%0d]: obs=%b addr=%0d, expected obs=%b addr=%0d",
                 i, obs, address, q[i][13:4], q[i][3:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    logic [20:0] q[$];
    pulse_reset();
    q = '{iss(4'b0010, IDL, 4'd0), nx(LA, 4'd0),
          row(1'b1, 1'b0, 4'hB, 1'b1, SLB, 4'd1),
          row(1'b1, 1'b0, 4'hB, 1'b1, SLB, 4'd1),
          row(1'b1, 1'b0, 4'hB, 1'b1, SLB, 4'd1),
          nx(LB, 4'd1),
          row(1'b1, 1'b1, 4'b0000, 1'b1, SEX, 4'd2),               // op ignored while stalled
          nx(ex(1'b0, 3'b001), 4'd2),
          row(1'b1, 1'b1, 4'b0000, 1'b1, IDL, 4'd2),
          nx(IDL, 4'd2)};
    foreach (q[i]) begin
      {reset, op, opcode, stall} = q[i][20:14];
      #1;
      n_cmp++;
      if (obs !== q[i][13:4] || address !== q[i][3:0]) begin
        n_err++;
        $display("FAIL stall[%0d]: obs=%b addr=%0d, expected obs=%b addr=%0d",
                 i, obs, address, q[i][13:4], q[i][3:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_midop_reset();
    logic [20:0] q[$];
    pulse_reset();
    q = '{iss(4'b0000, IDL, 4'd0),
          row(1'b0, 1'b0, 4'hB, 1'b0, LA, 4'd0),
          nx(IDL, 4'd0), nx(IDL, 4'd0), nx(IDL, 4'd0),
          iss(4'b0000, IDL, 4'd0), nx(LA, 4'd0),
          row(1'b0, 1'b0, 4'hB, 1'b0, LB, 4'd1),
          nx(IDL, 4'd0),
          row(1'b0, 1'b1, 4'b1111, 1'b0, IDL, 4'd0),                // reset beats illegal
          nx(IDL, 4'd0)};
    foreach (q[i]) begin
      {reset, op, opcode, stall} = q[i][20:14];
      #1;
      n_cmp++;
      if (obs !== q[i][13:4] || address !== q[i][3:0]) begin
        n_err++;
        $display("FAIL midop_reset[%0d]: obs=%b addr=%0d, expected obs=%b addr=%0d",
                 i, obs, address, q[i][13:4], q[i][3:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap();
    logic [20:0] q[$];
    w_reset = 1'b0; w_op = 1'b0; w_opcode = 4'h0; w_stall = 1'b0;
    @(posedge clk); #1;
    q = '{iss(4'b0110, IDL, 4'd3), nx(LA, 4'd3), nx(LB, 4'd0),
          nx(ex(1'b0, 3'b011), 4'd1), nx(IDL, 4'd1)};
    foreach (q[i]) begin
      {w_reset, w_op, w_opcode, w_stall} = q[i][20:14];
      #1;
      n_cmp++;
      if (w_obs !== q[i][13:4] || {2'b00, w_address} !== q[i][3:0]) begin
        n_err++;
        $display("FAIL wrap[%0d]: obs=%b addr=%0d, expected obs=%b addr=%0d",
                 i, w_obs, w_address, q[i][13:4], q[i][3:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b0; op = 1'b0; opcode = 4'h0; stall = 1'b0;
    w_reset = 1'b0; w_op = 1'b0; w_opcode = 4'h0; w_stall = 1'b0;
    test_reset();
    test_sweep();
    test_back_to_back();
    test_stall();
    test_midop_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
